// File: rtl/pinaipple_chip_pkg.sv
// Shared types for the memristor-array chip sequencer.
//   op_e        : request opcode, encoding equals the chip instruction code
//   seq_state_e : sequencer phase
//   strobe_t    : chip strobe bundle {cbl, cblen, csl, cwl}
//   op_strobes  : strobe pattern driven during PULSE/SAMPLE for a given op
package pinaipple_chip_pkg;

  typedef enum logic [1:0] {
    OP_INFER    = 2'b00,
    OP_READ_REG = 2'b01,
    OP_READ_MEM = 2'b10,
    OP_PROG     = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StSample,
    StHold,
    StResp
  } seq_state_e;

  typedef struct packed {
    logic cbl;
    logic cblen;
    logic csl;
    logic cwl;
  } strobe_t;

  localparam strobe_t StrobesOff = '0;

  function automatic strobe_t op_strobes(op_e op, logic wdata);
    strobe_t s;
    s = StrobesOff;
    case (op)
      OP_PROG: begin
        s.cbl   = wdata;
        s.cblen = 1'b1;
        s.csl   = 1'b0;
        s.cwl   = 1'b1;
      end
      OP_READ_MEM: begin
        s.cbl   = 1'b0;
        s.cblen = 1'b1;
        s.csl   = 1'b1;
        s.cwl   = 1'b1;
      end
      OP_READ_REG: begin
        s.cbl   = 1'b0;
        s.cblen = 1'b0;
        s.csl   = 1'b1;
        s.cwl   = 1'b0;
      end
      default: begin // OP_INFER
        s.cbl   = 1'b0;
        s.cblen = 1'b0;
        s.csl   = 1'b1;
        s.cwl   = 1'b1;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/chip_data_sync.sv
// Multi-flop synchroniser for the asynchronous chip data return.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset, clears every stage to 0
//   data_i  : asynchronous input bus
//   data_o  : synchronised bus, SYNC_STG cycles behind data_i
module chip_data_sync #(
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned WIDTH    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [SYNC_STG-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[SYNC_STG-2:0], data_i};
    end
  end

  assign data_o = stage_q[SYNC_STG-1];

endmodule

// File: rtl/chip_array_sequencer.sv
// Sequencer between the accelerator request port and the memristor-array chip pins.
// Takes one request at a time, drives instr/addr for SETUP_CYC cycles, asserts the
// op-specific strobes for PULSE_CYC cycles (plus the sample window for read ops),
// holds instr/addr for HOLD_CYC cycles and then pulses rsp_valid_o for one cycle.
// Ports:
//   clk_i, rst_ni                     : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o           : request handshake (ready only in IDLE)
//   req_op_i, req_col_i, req_row_i,
//   req_wdata_i                       : request fields, latched on accept
//   rsp_valid_o, rsp_data_o           : one-cycle response strobe and captured data
//   busy_o                            : high whenever not IDLE
//   chip_clk_o                        : forwarded clk_i
//   cbl_o, cblen_o, csl_o, cwl_o      : chip strobes
//   instr_o, addr_col_o, addr_row_o   : chip instruction and address
//   chip_data_i                       : asynchronous chip data return
// Configuration macro SEQ_MULTI_SAMPLE_EN: sample window widened by two cycles and the
// last three synchronised samples are majority-voted per bit.
module chip_array_sequencer
  import pinaipple_chip_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned PULSE_CYC = 8,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [1:0] req_op_i,
  input  logic [4:0] req_col_i,
  input  logic [4:0] req_row_i,
  input  logic       req_wdata_i,
  output logic       rsp_valid_o,
  output logic [3:0] rsp_data_o,
  output logic       busy_o,
  output logic       chip_clk_o,
  output logic       cbl_o,
  output logic       cblen_o,
  output logic       csl_o,
  output logic       cwl_o,
  output logic [1:0] instr_o,
  output logic [4:0] addr_col_o,
  output logic [4:0] addr_row_o,
  input  logic [3:0] chip_data_i
);

`ifdef SEQ_MULTI_SAMPLE_EN
  localparam int unsigned SampleCyc = SYNC_STG + 2;
`else
  localparam int unsigned SampleCyc = SYNC_STG;
`endif

  localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MaxHs  = (HOLD_CYC > SampleCyc) ? HOLD_CYC : SampleCyc;
  localparam int unsigned MaxCyc = (MaxSp > MaxHs) ? MaxSp : MaxHs;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  // Counter load values: each phase runs while the counter walks down to zero.
  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] PulseLd  = CntW'(PULSE_CYC - 1);
  localparam logic [CntW-1:0] SampleLd = CntW'(SampleCyc - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYC - 1);

  seq_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  op_e             instr_q;
  logic [4:0]      col_q;
  logic [4:0]      row_q;
  logic            wdata_q;
  strobe_t         strobe_q;
  logic            ready_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [3:0]      rsp_data_q;
  logic [3:0]      sync_data;
  logic [3:0]      capture;

  chip_data_sync #(
    .SYNC_STG (SYNC_STG),
    .WIDTH    (4)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .data_i (chip_data_i),
    .data_o (sync_data)
  );

`ifdef SEQ_MULTI_SAMPLE_EN
  // Two previous synchronised samples; the current one completes the vote.
  logic [1:0][3:0] hist_q;

  always_comb begin
    capture = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync_data) | (hist_q[0] & sync_data);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else if (state_q == StSample) begin
      hist_q <= {hist_q[0], sync_data};
    end
  end
`else
  always_comb begin
    capture = sync_data;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      instr_q     <= OP_INFER;
      col_q       <= '0;
      row_q       <= '0;
      wdata_q     <= 1'b0;
      strobe_q    <= StrobesOff;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            instr_q    <= op_e'(req_op_i);
            col_q      <= req_col_i;
            row_q      <= req_row_i;
            wdata_q    <= req_wdata_i;
            rsp_data_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= SetupLd;
            state_q    <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            strobe_q <= op_strobes(instr_q, wdata_q);
            cnt_q    <= PulseLd;
            state_q  <= StPulse;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPulse: begin
          if (cnt_q == '0) begin
            if (instr_q == OP_PROG) begin
              // Programming returns nothing, so skip the sample window.
              strobe_q <= StrobesOff;
              cnt_q    <= HoldLd;
              state_q  <= StHold;
            end else begin
              cnt_q   <= SampleLd;
              state_q <= StSample;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StSample: begin
          if (cnt_q == '0) begin
            rsp_data_q <= capture;
            strobe_q   <= StrobesOff;
            cnt_q      <= HoldLd;
            state_q    <= StHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          // Park the chip bus at zero between requests.
          instr_q <= OP_INFER;
          col_q   <= '0;
          row_q   <= '0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          strobe_q <= StrobesOff;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          cnt_q    <= '0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

  assign chip_clk_o  = clk_i;
  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign cbl_o       = strobe_q.cbl;
  assign cblen_o     = strobe_q.cblen;
  assign csl_o       = strobe_q.csl;
  assign cwl_o       = strobe_q.cwl;
  assign instr_o     = instr_q;
  assign addr_col_o  = col_q;
  assign addr_row_o  = row_q;

endmodule

// File: tb/tb_chip_array_sequencer.sv
// Self-checking bench for chip_array_sequencer: a table of directed requests, hand-written
// corner sequences (reset, back-to-back, reset mid-pulse, data glitch) and random requests
// checked cycle by cycle against a timeline model of the request.
module tb_chip_array_sequencer;

  localparam int S = 4;
  localparam int P = 8;
  localparam int H = 2;
  localparam int Y = 2;
`ifdef SEQ_MULTI_SAMPLE_EN
  localparam int SAMP = Y + 2;
`else
  localparam int SAMP = Y;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic [1:0] req_op_i = 2'b00;
  logic [4:0] req_col_i = '0;
  logic [4:0] req_row_i = '0;
  logic       req_wdata_i = 1'b0;
  logic       rsp_valid_o;
  logic [3:0] rsp_data_o;
  logic       busy_o;
  logic       chip_clk_o;
  logic       cbl_o, cblen_o, csl_o, cwl_o;
  logic [1:0] instr_o;
  logic [4:0] addr_col_o, addr_row_o;
  logic [3:0] chip_data_i = '0;

  int checks = 0;
  int errors = 0;

  chip_array_sequencer #(
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H),
    .SYNC_STG  (Y)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_col_i   (req_col_i),
    .req_row_i   (req_row_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o),
    .chip_clk_o  (chip_clk_o),
    .cbl_o       (cbl_o),
    .cblen_o     (cblen_o),
    .csl_o       (csl_o),
    .cwl_o       (cwl_o),
    .instr_o     (instr_o),
    .addr_col_o  (addr_col_o),
    .addr_row_o  (addr_row_o),
    .chip_data_i (chip_data_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: strobe pattern {cbl,cblen,csl,cwl}, latency, response value.
  function automatic logic [3:0] model_strb(input logic [1:0] op, input logic wdata);
    case (op)
      2'b11:   return {wdata, 3'b101};
      2'b10:   return 4'b0111;
      2'b01:   return 4'b0010;
      default: return 4'b0011;
    endcase
  endfunction

  function automatic int model_samp(input logic [1:0] op);
    return (op == 2'b11) ? 0 : SAMP;
  endfunction

  function automatic logic [3:0] strobes();
    return {cbl_o, cblen_o, csl_o, cwl_o};
  endfunction

  // Present a request and wait for its accept edge; returns just after that edge.
  task automatic issue(input logic [1:0] op, input logic [4:0] col, input logic [4:0] row,
                       input logic wdata, input logic [3:0] data, input bit keep);
    int t;
    @(negedge clk_i);
    req_op_i    = op;
    req_col_i   = col;
    req_row_i   = row;
    req_wdata_i = wdata;
    chip_data_i = data;
    req_valid_i = 1'b1;
    t = 0;
    while (!req_ready_o && t < 50) begin
      @(negedge clk_i);
      t++;
    end
    chk("ready_wait", {31'b0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    if (!keep) req_valid_i = 1'b0;
  endtask

  // Check one request cycle by cycle, starting the cycle after its accept edge.
  task automatic expect_txn(input logic [1:0] op, input logic [4:0] col, input logic [4:0] row,
                            input logic [3:0] exp_strb, input logic [3:0] exp_rsp,
                            input bit drop, input int glitch_k);
    int sa, lat;
    logic [3:0] es;
    logic [3:0] saved;
    saved = chip_data_i;
    sa  = model_samp(op);
    lat = S + P + sa + H + 1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk_i);
      es = (k >= S + 1 && k <= S + P + sa) ? exp_strb : 4'b0000;
      chk("strobes", {28'b0, strobes()}, {28'b0, es});
      if (k <= lat - 1) begin
        chk("instr", {30'b0, instr_o}, {30'b0, op});
        chk("addr_col", {27'b0, addr_col_o}, {27'b0, col});
        chk("addr_row", {27'b0, addr_row_o}, {27'b0, row});
      end
      chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, (k == lat)});
      if (k == lat) chk("rsp_data", {28'b0, rsp_data_o}, {28'b0, exp_rsp});
      chk("busy", {31'b0, busy_o}, {31'b0, (k <= lat)});
      chk("ready", {31'b0, req_ready_o}, {31'b0, (k > lat)});
      if (drop && k == 1) req_valid_i = 1'b0;
      if (k == glitch_k) chip_data_i = 4'h0;
      if (k == glitch_k + 1) chip_data_i = saved;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [4:0] col;
    logic [4:0] row;
    logic       wdata;
    logic [3:0] data;
    logic [3:0] exp_strb;
    logic [3:0] exp_rsp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] rop;
    logic [4:0] rcol, rrow;
    logic       rw;
    logic [3:0] rd;
    bit         seen;

    vecs[0] = '{op: 2'b10, col: 5'h13, row: 5'h07, wdata: 1'b0, data: 4'hA,
                exp_strb: 4'b0111, exp_rsp: 4'hA};
    vecs[1] = '{op: 2'b11, col: 5'h02, row: 5'h1C, wdata: 1'b1, data: 4'h9,
                exp_strb: 4'b1101, exp_rsp: 4'h0};
    vecs[2] = '{op: 2'b11, col: 5'h1F, row: 5'h00, wdata: 1'b0, data: 4'hF,
                exp_strb: 4'b0101, exp_rsp: 4'h0};
    vecs[3] = '{op: 2'b01, col: 5'h00, row: 5'h1F, wdata: 1'b1, data: 4'h5,
                exp_strb: 4'b0010, exp_rsp: 4'h5};
    vecs[4] = '{op: 2'b00, col: 5'h0A, row: 5'h15, wdata: 1'b0, data: 4'hC,
                exp_strb: 4'b0011, exp_rsp: 4'hC};
    vecs[5] = '{op: 2'b10, col: 5'h1F, row: 5'h1F, wdata: 1'b1, data: 4'h6,
                exp_strb: 4'b0111, exp_rsp: 4'h6};

    // Reset held with a valid request pending: nothing is accepted, outputs idle.
    req_valid_i = 1'b1;
    req_op_i    = 2'b01;
    req_col_i   = 5'h11;
    req_row_i   = 5'h04;
    chip_data_i = 4'h3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("rst_strobes", {28'b0, strobes()}, 32'd0);
      chk("rst_instr", {30'b0, instr_o}, 32'd0);
      chk("rst_addr", {22'b0, addr_col_o, addr_row_o}, 32'd0);
      chk("rst_rsp", {27'b0, rsp_valid_o, rsp_data_o}, 32'd0);
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
    end
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    expect_txn(2'b01, 5'h11, 5'h04, 4'b0010, 4'h3, 1'b0, -1);

    // Directed table.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].col, vecs[i].row, vecs[i].wdata, vecs[i].data, 1'b0);
      expect_txn(vecs[i].op, vecs[i].col, vecs[i].row, vecs[i].exp_strb, vecs[i].exp_rsp,
                 1'b0, -1);
    end

    // Back-to-back with valid held: second request taken the cycle after RESP.
    issue(2'b01, 5'h05, 5'h06, 1'b0, 4'h9, 1'b1);
    req_op_i  = 2'b00;
    req_col_i = 5'h17;
    req_row_i = 5'h08;
    expect_txn(2'b01, 5'h05, 5'h06, 4'b0010, 4'h9, 1'b0, -1);
    expect_txn(2'b00, 5'h17, 5'h08, 4'b0011, 4'h9, 1'b1, -1);

    // Reset in the middle of PULSE: strobes drop at once, no response follows.
    issue(2'b10, 5'h0C, 5'h03, 1'b0, 4'hB, 1'b0);
    for (int k = 1; k <= S + 3; k++) @(negedge clk_i);
    chk("pulse_strobes", {28'b0, strobes()}, 32'h7);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_strobes", {28'b0, strobes()}, 32'd0);
    chk("async_busy", {31'b0, busy_o}, 32'd0);
    chk("async_ready", {31'b0, req_ready_o}, 32'd1);
    chk("async_instr", {20'b0, instr_o, addr_col_o, addr_row_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      if (rsp_valid_o || busy_o) seen = 1'b1;
    end
    chk("no_rsp_after_rst", {31'b0, seen}, 32'd0);
    issue(2'b10, 5'h0C, 5'h03, 1'b0, 4'hB, 1'b0);
    expect_txn(2'b10, 5'h0C, 5'h03, 4'b0111, 4'hB, 1'b0, -1);

    // One-cycle data glitch in the first SAMPLE cycle must not reach the response.
    issue(2'b10, 5'h01, 5'h02, 1'b0, 4'hF, 1'b0);
    expect_txn(2'b10, 5'h01, 5'h02, 4'b0111, 4'hF, 1'b0, S + P + 1);

    // Random requests against the model.
    for (int n = 0; n < 30; n++) begin
      rop  = 2'($urandom_range(0, 3));
      rcol = 5'($urandom);
      rrow = 5'($urandom);
      rw   = 1'($urandom);
      rd   = 4'($urandom);
      issue(rop, rcol, rrow, rw, rd, 1'b0);
      expect_txn(rop, rcol, rrow, model_strb(rop, rw), (rop == 2'b11) ? 4'h0 : rd, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
